// File: rtl/nubus_video_pkg.sv
// Shared types and line geometry for the NuBus video card VRAM path.
package nubus_video_pkg;

  typedef enum logic [1:0] {
    IDLE,
    VID_RD,
    CPU_RD,
    CPU_WR
  } ARB_STATE_T;

  localparam int unsigned VRAM_WORDS     = 153600;
  localparam int unsigned MAX_LINE_WORDS = 320;

endpackage

// File: rtl/nubus_vram_line_fifo.sv
// First-word-fall-through scanline FIFO with registered head, level output,
// synchronous flush and a one-cycle underflow pulse.
module nubus_vram_line_fifo #(
  parameter int unsigned DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     flush,
  input  logic                     push,
  input  logic [15:0]              din,
  input  logic                     pop,
  output logic [15:0]              dout,
  output logic                     empty,
  output logic                     underflow,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] LVL_ONE = (AW+1)'(1);

  logic [15:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] rd_next;
  logic          do_push;
  logic          do_pop;
  logic [15:0]   head_next;

  assign do_push = push && !flush;
  assign do_pop  = pop && !flush && (level != '0);
  assign rd_next = rd_ptr + 1'b1;
  assign empty   = (level == '0);

  // Head register tracks mem[rd_ptr]; when the FIFO is (or becomes) empty
  // the incoming word bypasses the array so it appears on the next edge.
  always_comb begin
    head_next = dout;
    if (do_pop) begin
      if (level != LVL_ONE) head_next = mem[rd_next];
      else if (do_push)     head_next = din;
    end else if (empty && do_push) begin
      head_next = din;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      level     <= '0;
      dout      <= '0;
      underflow <= 1'b0;
    end else begin
      underflow <= pop && !flush && empty;
      dout      <= head_next;
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        level  <= '0;
      end else begin
        if (do_push) wr_ptr <= wr_ptr + 1'b1;
        if (do_pop)  rd_ptr <= rd_next;
        case ({do_push, do_pop})
          2'b10:   level <= level + 1'b1;
          2'b01:   level <= level - 1'b1;
          default: ;
        endcase
      end
    end
  end

endmodule

// File: rtl/nubus_vram_arbiter.sv
// Arbitrates the single SDRAM VRAM port between scanline prefetch and
// CPU word access, with a bounded deferral of the CPU by urgent video.
module nubus_vram_arbiter
  import nubus_video_pkg::*;
#(
  parameter int unsigned ADDR_W        = 25,
  parameter int unsigned FIFO_DEPTH    = 16,
  parameter int unsigned LOW_WATER     = 4,
  parameter int unsigned CPU_DEFER_MAX = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              vid_line_start,
  input  logic [ADDR_W-1:0] vid_base,
  input  logic [8:0]        vid_words,
  input  logic              vid_pop,
  output logic [15:0]       vid_data,
  output logic              vid_empty,
  output logic              vid_underflow,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [15:0]       cpu_wdata,
  output logic [15:0]       cpu_rdata,
  output logic              cpu_done,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [15:0]       mem_dout,
  output logic              mem_rd,
  output logic              mem_wr,
  input  logic [15:0]       mem_din,
  input  logic              mem_ready
);

  localparam int unsigned LW = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned DW = $clog2(CPU_DEFER_MAX + 1);
  localparam logic [LW-1:0] LOW_LVL   = LW'(LOW_WATER);
  localparam logic [LW-1:0] FULL_LVL  = LW'(FIFO_DEPTH);
  localparam logic [DW-1:0] DEFER_CAP = DW'(CPU_DEFER_MAX);

  ARB_STATE_T        state_q;
  ARB_STATE_T        state_d;
  logic [ADDR_W-1:0] vid_ptr;
  logic [8:0]        remaining;
  logic [DW-1:0]     defer_cnt;
  logic              discard_q;
  logic [LW-1:0]     fifo_level;
  logic              cpu_pending;
  logic              vid_have;
  logic              urgent;
  logic              vid_push;
  logic              cpu_xfer;

  // cpu_req stays high through the cpu_done cycle; that cycle must not regrant.
  assign cpu_pending = cpu_req && !cpu_done;
  assign vid_have    = (remaining != '0) && !vid_line_start;
  assign urgent      = vid_have && (fifo_level < LOW_LVL) &&
                       !(cpu_pending && (defer_cnt == DEFER_CAP));
  assign vid_push    = (state_q == VID_RD) && mem_ready && !discard_q && !vid_line_start;
  assign cpu_xfer    = (state_q == CPU_RD) || (state_q == CPU_WR);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (urgent)                                     state_d = VID_RD;
        else if (cpu_pending)                           state_d = cpu_we ? CPU_WR : CPU_RD;
        else if (vid_have && (fifo_level < FULL_LVL))   state_d = VID_RD;
      end
      default: if (mem_ready) state_d = IDLE;
    endcase
  end

  always_comb begin
    mem_rd = 1'b0;
    mem_wr = 1'b0;
    unique case (state_q)
      VID_RD, CPU_RD: mem_rd = 1'b1;
      CPU_WR:         mem_wr = 1'b1;
      default:        ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mem_addr  <= '0;
      mem_dout  <= '0;
      cpu_rdata <= '0;
      cpu_done  <= 1'b0;
      vid_ptr   <= '0;
      remaining <= '0;
      defer_cnt <= '0;
      discard_q <= 1'b0;
    end else begin
      cpu_done <= cpu_xfer && mem_ready;
      if (state_q == CPU_RD && mem_ready) cpu_rdata <= mem_din;

      if (state_q == IDLE) begin
        if (state_d == VID_RD) begin
          mem_addr <= vid_ptr;
          if (cpu_pending) defer_cnt <= defer_cnt + 1'b1;
        end else if (state_d != IDLE) begin
          mem_addr  <= cpu_addr;
          defer_cnt <= '0;
          if (state_d == CPU_WR) mem_dout <= cpu_wdata;
        end
      end

      if (vid_line_start) begin
        vid_ptr   <= vid_base;
        remaining <= vid_words;
      end else if (vid_push) begin
        vid_ptr   <= vid_ptr + 1'b1;
        remaining <= remaining - 1'b1;
      end

      // A read in flight across a line restart finishes but its word is dropped.
      if (state_q == VID_RD && mem_ready) discard_q <= 1'b0;
      if (vid_line_start && state_q == VID_RD && !mem_ready) discard_q <= 1'b1;
    end
  end

  nubus_vram_line_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .flush     (vid_line_start),
    .push      (vid_push),
    .din       (mem_din),
    .pop       (vid_pop),
    .dout      (vid_data),
    .empty     (vid_empty),
    .underflow (vid_underflow),
    .level     (fifo_level)
  );

endmodule

// File: tb/tb_nubus_vram_arbiter.sv
// Scoreboard bench for nubus_vram_arbiter with a latency-programmable SDRAM responder.
module tb_nubus_vram_arbiter;
  import nubus_video_pkg::*;

  localparam int unsigned ADDR_W = 25;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              vid_line_start;
  logic [ADDR_W-1:0] vid_base;
  logic [8:0]        vid_words;
  logic              vid_pop;
  logic [15:0]       vid_data;
  logic              vid_empty;
  logic              vid_underflow;
  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [15:0]       cpu_wdata;
  logic [15:0]       cpu_rdata;
  logic              cpu_done;
  logic [ADDR_W-1:0] mem_addr;
  logic [15:0]       mem_dout;
  logic              mem_rd;
  logic              mem_wr;
  logic [15:0]       mem_din;
  logic              mem_ready;

  typedef struct {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [15:0]       dout;
  } txn_t;

  txn_t        obs_q[$];
  txn_t        exp_q[$];
  logic [15:0] exp_data_q[$];
  int          checks = 0;
  int          errors = 0;
  int          lat = 2;

  always #5 clk = ~clk;

  nubus_vram_arbiter #(
    .ADDR_W        (ADDR_W),
    .FIFO_DEPTH    (16),
    .LOW_WATER     (4),
    .CPU_DEFER_MAX (4)
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .vid_line_start (vid_line_start),
    .vid_base       (vid_base),
    .vid_words      (vid_words),
    .vid_pop        (vid_pop),
    .vid_data       (vid_data),
    .vid_empty      (vid_empty),
    .vid_underflow  (vid_underflow),
    .cpu_req        (cpu_req),
    .cpu_we         (cpu_we),
    .cpu_addr       (cpu_addr),
    .cpu_wdata      (cpu_wdata),
    .cpu_rdata      (cpu_rdata),
    .cpu_done       (cpu_done),
    .mem_addr       (mem_addr),
    .mem_dout       (mem_dout),
    .mem_rd         (mem_rd),
    .mem_wr         (mem_wr),
    .mem_din        (mem_din),
    .mem_ready      (mem_ready)
  );

  function automatic logic [15:0] rd_val(input logic [ADDR_W-1:0] a);
    return a[15:0] ^ 16'hA5A5;
  endfunction

  function automatic txn_t mk(input logic we, input logic [ADDR_W-1:0] a, input logic [15:0] d);
    txn_t t;
    t.we = we; t.addr = a; t.dout = d;
    return t;
  endfunction

  // SDRAM model: ready after `lat` cycles of strobe, logs each completed transaction.
  initial begin
    int cnt;
    cnt = 0;
    mem_ready = 1'b0;
    mem_din = '0;
    forever begin
      @(negedge clk);
      if (mem_ready) begin
        mem_ready = 1'b0;
        cnt = 0;
      end else if (mem_rd || mem_wr) begin
        cnt++;
        if (cnt >= lat) begin
          mem_ready = 1'b1;
          mem_din = rd_val(mem_addr);
          obs_q.push_back(mk(mem_wr, mem_addr, mem_dout));
        end
      end else begin
        cnt = 0;
      end
    end
  end

  task automatic wait_obs(input int n, input int budget);
    int k;
    k = 0;
    while (obs_q.size() < n && k < budget) begin
      @(negedge clk);
      k++;
    end
  endtask

  task automatic quiesce();
    @(negedge clk);
    cpu_req = 1'b0; vid_pop = 1'b0;
    vid_line_start = 1'b1; vid_words = '0;
    @(negedge clk);
    vid_line_start = 1'b0;
    repeat (15) @(negedge clk);
    obs_q.delete();
    exp_q.delete();
    exp_data_q.delete();
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++;
    if ({mem_rd, mem_wr, cpu_done, vid_underflow, vid_empty} !== 5'b00001) begin
      errors++;
      $display("FAIL reset_flags: got %b expected 00001",
               {mem_rd, mem_wr, cpu_done, vid_underflow, vid_empty});
    end
    checks++;
    if ({mem_addr, mem_dout, cpu_rdata, vid_data} !== '0) begin
      errors++;
      $display("FAIL reset_data: addr=%h dout=%h rdata=%h vdata=%h expected all 0",
               mem_addr, mem_dout, cpu_rdata, vid_data);
    end
    checks++;
    if (dut.state_q !== IDLE || dut.fifo_level !== '0) begin
      errors++;
      $display("FAIL reset_state: state=%0d level=%0d expected 0/0", dut.state_q, dut.fifo_level);
    end
    @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_underflow();
    vid_pop = 1'b1;
    @(negedge clk);
    vid_pop = 1'b0;
    checks++;
    if (vid_underflow !== 1'b1 || vid_data !== 16'h0000 || dut.fifo_level !== '0) begin
      errors++;
      $display("FAIL underflow_pulse: uf=%b data=%h level=%0d expected 1/0000/0",
               vid_underflow, vid_data, dut.fifo_level);
    end
    @(negedge clk);
    checks++;
    if (vid_underflow !== 1'b0 || vid_empty !== 1'b1) begin
      errors++;
      $display("FAIL underflow_width: uf=%b empty=%b expected 0/1", vid_underflow, vid_empty);
    end
  endtask

  task automatic test_line_fill();
    lat = 2;
    for (int i = 0; i < 8; i++) begin
      exp_q.push_back(mk(1'b0, 25'h100 + 25'(i), 16'h0));
      exp_data_q.push_back(rd_val(25'h100 + 25'(i)));
    end
    vid_base = 25'h100; vid_words = 9'd8; vid_line_start = 1'b1;
    @(negedge clk);
    vid_line_start = 1'b0;
    wait_obs(8, 200);
    repeat (20) @(negedge clk);
    checks++;
    if (obs_q.size() != 8) begin
      errors++;
      $display("FAIL fill_count: got %0d reads expected 8", obs_q.size());
    end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      txn_t o, e;
      o = obs_q.pop_front(); e = exp_q.pop_front();
      checks++;
      if (o.we !== e.we || o.addr !== e.addr) begin
        errors++;
        $display("FAIL fill_txn: got we=%b addr=%h expected we=%b addr=%h", o.we, o.addr, e.we, e.addr);
      end
    end
    checks++;
    if (dut.fifo_level !== 5'd8) begin
      errors++;
      $display("FAIL fill_level: got %0d expected 8", dut.fifo_level);
    end
    for (int i = 0; i < 8; i++) begin
      logic [15:0] e;
      e = exp_data_q.pop_front();
      checks++;
      if (vid_data !== e) begin
        errors++;
        $display("FAIL fifo_data[%0d]: got %h expected %h", i, vid_data, e);
      end
      vid_pop = 1'b1;
      @(negedge clk);
    end
    vid_pop = 1'b0;
    checks++;
    if (vid_empty !== 1'b1) begin
      errors++;
      $display("FAIL fifo_drain: empty=%b expected 1", vid_empty);
    end
  endtask

  task automatic test_cpu_priority();
    int k;
    quiesce();
    for (int i = 0; i < 10; i++) exp_q.push_back(mk(1'b0, 25'h400 + 25'(i), 16'h0));
    vid_base = 25'h400; vid_words = 9'd20; vid_line_start = 1'b1;
    @(negedge clk);
    vid_line_start = 1'b0;
    k = 0;
    while (dut.fifo_level != 5'd10 && k < 300) begin
      @(negedge clk);
      k++;
    end
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 25'h2000; cpu_wdata = 16'hBEEF;
    exp_q.push_back(mk(1'b1, 25'h2000, 16'hBEEF));
    exp_q.push_back(mk(1'b0, 25'h40A, 16'h0));
    k = 0;
    while (!(mem_ready && mem_wr) && k < 50) begin
      @(negedge clk);
      k++;
    end
    checks++;
    if (!(mem_ready && mem_wr) || cpu_done !== 1'b0) begin
      errors++;
      $display("FAIL wr_ready: ready=%b wr=%b done=%b expected 1/1/0", mem_ready, mem_wr, cpu_done);
    end
    @(negedge clk);
    checks++;
    if (cpu_done !== 1'b1) begin
      errors++;
      $display("FAIL wr_done: got %b expected 1", cpu_done);
    end
    cpu_req = 1'b0;
    @(negedge clk);
    checks++;
    if (cpu_done !== 1'b0) begin
      errors++;
      $display("FAIL wr_done_pulse: got %b expected 0", cpu_done);
    end
    wait_obs(12, 50);
    checks++;
    if (obs_q.size() < 12) begin
      errors++;
      $display("FAIL prio_count: got %0d txns expected >= 12", obs_q.size());
    end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      txn_t o, e;
      o = obs_q.pop_front(); e = exp_q.pop_front();
      checks++;
      if (o.we !== e.we || o.addr !== e.addr || (e.we && o.dout !== e.dout)) begin
        errors++;
        $display("FAIL prio_txn: got we=%b addr=%h dout=%h expected we=%b addr=%h dout=%h",
                 o.we, o.addr, o.dout, e.we, e.addr, e.dout);
      end
    end
  endtask

  task automatic test_defer_cap();
    int k;
    bit done_seen;
    quiesce();
    for (int i = 0; i < 6; i++) exp_q.push_back(mk(1'b0, 25'h800 + 25'(i), 16'h0));
    exp_q.push_back(mk(1'b0, 25'h3000, 16'h0));
    vid_base = 25'h800; vid_words = 9'd100; vid_line_start = 1'b1;
    @(negedge clk);
    vid_line_start = 1'b0;
    k = 0;
    while (dut.fifo_level != 5'd2 && k < 100) begin
      @(negedge clk);
      k++;
    end
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 25'h3000;
    done_seen = 1'b0;
    for (int c = 0; c < 200 && !done_seen; c++) begin
      vid_pop = (dut.fifo_level > 5'd2);
      @(negedge clk);
      if (cpu_done) done_seen = 1'b1;
    end
    vid_pop = 1'b0;
    checks++;
    if (!done_seen || cpu_rdata !== rd_val(25'h3000)) begin
      errors++;
      $display("FAIL defer_rdata: done=%b rdata=%h expected 1/%h", done_seen, cpu_rdata, rd_val(25'h3000));
    end
    cpu_req = 1'b0;
    checks++;
    if (obs_q.size() < 7) begin
      errors++;
      $display("FAIL defer_count: got %0d txns expected >= 7", obs_q.size());
    end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      txn_t o, e;
      o = obs_q.pop_front(); e = exp_q.pop_front();
      checks++;
      if (o.we !== e.we || o.addr !== e.addr) begin
        errors++;
        $display("FAIL defer_txn: got we=%b addr=%h expected we=%b addr=%h", o.we, o.addr, e.we, e.addr);
      end
    end
  endtask

  task automatic test_line_start_inflight();
    int k;
    quiesce();
    lat = 6;
    exp_q.push_back(mk(1'b0, 25'hA00, 16'h0));
    for (int i = 0; i < 3; i++) exp_q.push_back(mk(1'b0, 25'hC00 + 25'(i), 16'h0));
    vid_base = 25'hA00; vid_words = 9'd5; vid_line_start = 1'b1;
    @(negedge clk);
    vid_line_start = 1'b0;
    k = 0;
    while (!mem_rd && k < 20) begin
      @(negedge clk);
      k++;
    end
    vid_base = 25'hC00; vid_words = 9'd3; vid_line_start = 1'b1;
    @(negedge clk);
    vid_line_start = 1'b0;
    checks++;
    if (vid_empty !== 1'b1 || dut.fifo_level !== '0) begin
      errors++;
      $display("FAIL restart_flush: empty=%b level=%0d expected 1/0", vid_empty, dut.fifo_level);
    end
    wait_obs(4, 200);
    repeat (20) @(negedge clk);
    checks++;
    if (obs_q.size() != 4) begin
      errors++;
      $display("FAIL restart_count: got %0d reads expected 4", obs_q.size());
    end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      txn_t o, e;
      o = obs_q.pop_front(); e = exp_q.pop_front();
      checks++;
      if (o.we !== e.we || o.addr !== e.addr) begin
        errors++;
        $display("FAIL restart_txn: got we=%b addr=%h expected we=%b addr=%h", o.we, o.addr, e.we, e.addr);
      end
    end
    checks++;
    if (dut.fifo_level !== 5'd3 || vid_data !== rd_val(25'hC00)) begin
      errors++;
      $display("FAIL restart_fifo: level=%0d data=%h expected 3/%h", dut.fifo_level, vid_data, rd_val(25'hC00));
    end
    lat = 2;
  endtask

  task automatic test_reset_midtxn();
    int k;
    quiesce();
    lat = 6;
    vid_base = 25'hE00; vid_words = 9'd4; vid_line_start = 1'b1;
    @(negedge clk);
    vid_line_start = 1'b0;
    k = 0;
    while (!mem_rd && k < 20) begin
      @(negedge clk);
      k++;
    end
    #2;
    reset_n = 1'b0;
    #1;
    checks++;
    if (mem_rd !== 1'b0 || cpu_done !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: mem_rd=%b done=%b expected 0/0", mem_rd, cpu_done);
    end
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    checks++;
    if (dut.state_q !== IDLE || vid_empty !== 1'b1 || mem_rd !== 1'b0) begin
      errors++;
      $display("FAIL post_reset: state=%0d empty=%b mem_rd=%b expected 0/1/0", dut.state_q, vid_empty, mem_rd);
    end
    repeat (10) @(negedge clk);
    checks++;
    if (obs_q.size() != 0 || mem_rd !== 1'b0 || cpu_done !== 1'b0) begin
      errors++;
      $display("FAIL post_reset_quiet: txns=%0d mem_rd=%b done=%b expected 0/0/0", obs_q.size(), mem_rd, cpu_done);
    end
    lat = 2;
  endtask

  initial begin
    reset_n = 1'b0;
    vid_line_start = 1'b0; vid_base = '0; vid_words = '0; vid_pop = 1'b0;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    repeat (3) @(negedge clk);
    test_reset();
    test_underflow();
    test_line_fill();
    test_cpu_priority();
    test_defer_cap();
    test_line_start_inflight();
    test_reset_midtxn();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
